alu_unit: RTL and testbench

Arithmetic/logic stage directly downstream of the register file: consumes its two read ports (OutA, OutB) as operands A and B and produces the result word that is written back through the register file input I. It contains:
- combinational single-cycle operations;
- a 4-bit flags register (Z, C, N, O);
- a multi-cycle 16x16 unsigned shift-add multiplier with a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/alu_multiplier.sv | 86 ++++++++
 rtl/alu_unit.sv | 122 ++++++++++++
 tb/tb_alu_unit.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU stage: opcodes, flag bit positions and
// the multiplier FSM state encoding.
package alu_pkg;

  localparam logic [3:0] FS_A    = 4'h0;
  localparam logic [3:0] FS_B    = 4'h1;
  localparam logic [3:0] FS_NOTA = 4'h2;
  localparam logic [3:0] FS_NOTB = 4'h3;
  localparam logic [3:0] FS_ADD  = 4'h4;
  localparam logic [3:0] FS_ADC  = 4'h5;
  localparam logic [3:0] FS_SUB  = 4'h6;
  localparam logic [3:0] FS_AND  = 4'h7;
  localparam logic [3:0] FS_OR   = 4'h8;
  localparam logic [3:0] FS_XOR  = 4'h9;
  localparam logic [3:0] FS_NAND = 4'hA;
  localparam logic [3:0] FS_LSL  = 4'hB;
  localparam logic [3:0] FS_LSR  = 4'hC;
  localparam logic [3:0] FS_ASR  = 4'hD;
  localparam logic [3:0] FS_CSL  = 4'hE;
  localparam logic [3:0] FS_MUL  = 4'hF;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_O = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/alu_multiplier.sv
// Unsigned shift-add multiplier, one partial product per clock, with a
// start/busy/done handshake and a registered product.
module alu_multiplier
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               start,
  input  logic               wf_in,
  output logic               busy,
  output logic               done,
  output logic               finish,
  output logic [2*WIDTH-1:0] final_product,
  output logic [2*WIDTH-1:0] product,
  output logic               wf_mul
);

  localparam int CNT_W = $clog2(MUL_CYCLES);

  mul_state_e         state_reg, state_next;
  logic [CNT_W-1:0]   count_reg;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] product_reg;
  logic               wf_mul_reg;

  logic               accept;
  logic               last;
  logic [2*WIDTH-1:0] acc_step;

  // Start is dropped while a multiply is in flight.
  assign accept   = start && (state_reg != ST_RUN);
  assign last     = (state_reg == ST_RUN) && (count_reg == CNT_W'(MUL_CYCLES - 1));
  assign acc_step = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (accept) state_next = ST_RUN;
      ST_RUN:  if (last) state_next = ST_DONE;
      ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      count_reg   <= '0;
      mcand_reg   <= '0;
      mplier_reg  <= '0;
      acc_reg     <= '0;
      product_reg <= '0;
      wf_mul_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        mcand_reg  <= {{WIDTH{1'b0}}, a};
        mplier_reg <= b;
        acc_reg    <= '0;
        count_reg  <= '0;
        wf_mul_reg <= wf_in;
      end else if (state_reg == ST_RUN) begin
        acc_reg    <= acc_step;
        mcand_reg  <= mcand_reg << 1;
        mplier_reg <= mplier_reg >> 1;
        count_reg  <= count_reg + 1'b1;
        if (last) product_reg <= acc_step;
      end
    end
  end

  assign busy          = (state_reg == ST_RUN);
  assign done          = (state_reg == ST_DONE);
  assign finish        = last;
  assign final_product = acc_step;
  assign product       = product_reg;
  assign wf_mul        = wf_mul_reg;

endmodule

// File: rtl/alu_unit.sv
// ALU stage: combinational operation mux, Z/C/N/O flags register and the
// multi-cycle multiplier.
module alu_unit
  import alu_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MUL_CYCLES = 16
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       FunSel,
  input  logic             WF,
  input  logic             Start,
  output logic [WIDTH-1:0] ALUOut,
  output logic [WIDTH-1:0] MulHi,
  output logic [3:0]       FlagsOut,
  output logic             Busy,
  output logic             Done
);

  logic [3:0]         flags_reg, flags_next;
  logic [WIDTH-1:0]   result;
  logic [WIDTH:0]     sum;
  logic               c_new, o_new;
  logic               mul_finish, mul_wf;
  logic [2*WIDTH-1:0] mul_final, mul_product;

  alu_multiplier #(
    .WIDTH      (WIDTH),
    .MUL_CYCLES (MUL_CYCLES)
  ) u_mul (
    .clk           (Clock),
    .rst           (Reset),
    .a             (A),
    .b             (B),
    .start         (Start && (FunSel == FS_MUL)),
    .wf_in         (WF),
    .busy          (Busy),
    .done          (Done),
    .finish        (mul_finish),
    .final_product (mul_final),
    .product       (mul_product),
    .wf_mul        (mul_wf)
  );

  // C and O default to holding; only ops that define them override.
  always_comb begin
    result = '0;
    sum    = '0;
    c_new  = flags_reg[FLAG_C];
    o_new  = flags_reg[FLAG_O];
    case (FunSel)
      FS_A:    result = A;
      FS_B:    result = B;
      FS_NOTA: result = ~A;
      FS_NOTB: result = ~B;
      FS_ADD, FS_ADC: begin
        sum    = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, (FunSel == FS_ADC) && flags_reg[FLAG_C]};
        result = sum[WIDTH-1:0];
        c_new  = sum[WIDTH];
        o_new  = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      FS_SUB: begin
        sum    = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        result = sum[WIDTH-1:0];
        c_new  = sum[WIDTH];
        o_new  = (A[WIDTH-1] != B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      FS_AND:  result = A & B;
      FS_OR:   result = A | B;
      FS_XOR:  result = A ^ B;
      FS_NAND: result = ~(A & B);
      FS_LSL: begin
        result = {A[WIDTH-2:0], 1'b0};
        c_new  = A[WIDTH-1];
      end
      FS_LSR: begin
        result = {1'b0, A[WIDTH-1:1]};
        c_new  = A[0];
      end
      FS_ASR: begin
        result = {A[WIDTH-1], A[WIDTH-1:1]};
        c_new  = 1'b0;
      end
      FS_CSL: begin
        result = {A[WIDTH-2:0], flags_reg[FLAG_C]};
        c_new  = A[WIDTH-1];
      end
      default: result = '0;
    endcase
  end

  // The multiplier owns the flags while running and at its completion edge.
  always_comb begin
    flags_next = flags_reg;
    if (mul_finish) begin
      if (mul_wf) begin
        flags_next[FLAG_Z] = (mul_final == '0);
        flags_next[FLAG_C] = |mul_final[2*WIDTH-1:WIDTH];
        flags_next[FLAG_N] = mul_final[WIDTH-1];
        flags_next[FLAG_O] = 1'b0;
      end
    end else if (WF && !Busy && (FunSel != FS_MUL)) begin
      flags_next[FLAG_Z] = (result == '0);
      flags_next[FLAG_C] = c_new;
      flags_next[FLAG_N] = result[WIDTH-1];
      flags_next[FLAG_O] = o_new;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) flags_reg <= '0;
    else       flags_reg <= flags_next;
  end

  assign ALUOut   = (FunSel == FS_MUL) ? mul_product[WIDTH-1:0] : result;
  assign MulHi    = mul_product[2*WIDTH-1:WIDTH];
  assign FlagsOut = flags_reg;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized traffic
// compared every cycle against an arithmetic reference model.
module tb_alu_unit;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [15:0] A = '0, B = '0;
  logic [3:0]  FunSel = '0;
  logic        WF = 1'b0, Start = 1'b0;
  logic [15:0] ALUOut, MulHi;
  logic [3:0]  FlagsOut;
  logic        Busy, Done;

  int n_checks = 0;
  int n_fail   = 0;

  alu_unit #(.WIDTH(16), .MUL_CYCLES(16)) dut (
    .Clock(Clock), .Reset(Reset), .A(A), .B(B), .FunSel(FunSel), .WF(WF),
    .Start(Start), .ALUOut(ALUOut), .MulHi(MulHi), .FlagsOut(FlagsOut),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic on plain integers.
  function automatic void ref_op(input logic [3:0] fs, input logic [15:0] a, input logic [15:0] b,
                                 input logic cin, output logic [15:0] r, output logic c,
                                 output logic o, output logic cv, output logic ov);
    int ua, ub, sa, sb, s, ss;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    r = '0; c = 1'b0; o = 1'b0; cv = 1'b0; ov = 1'b0;
    case (fs)
      4'h0: r = a;
      4'h1: r = b;
      4'h2: r = ~a;
      4'h3: r = ~b;
      4'h4, 4'h5: begin
        s  = ua + ub + ((fs == 4'h5) ? int'(cin) : 0);
        ss = sa + sb + ((fs == 4'h5) ? int'(cin) : 0);
        r = s[15:0]; c = (s > 65535); o = (ss > 32767 || ss < -32768); cv = 1; ov = 1;
      end
      4'h6: begin
        s  = ua - ub;
        ss = sa - sb;
        r = s[15:0]; c = (ua >= ub); o = (ss > 32767 || ss < -32768); cv = 1; ov = 1;
      end
      4'h7: r = a & b;
      4'h8: r = a | b;
      4'h9: r = a ^ b;
      4'hA: r = ~(a & b);
      4'hB: begin r = 16'(ua * 2);   c = (ua >= 32768); cv = 1; end
      4'hC: begin r = 16'(ua / 2);   c = (ua % 2 == 1); cv = 1; end
      4'hD: begin r = 16'(sa >>> 1); c = 1'b0;          cv = 1; end
      4'hE: begin r = 16'(ua * 2 + int'(cin)); c = (ua >= 32768); cv = 1; end
      default: r = '0;
    endcase
  endfunction

  // Model: a multiply is a countdown of 16 edges ending with a=A*B.
  logic [3:0]  m_flags;
  logic [31:0] m_prod, m_pend;
  logic        m_done, m_wf;
  int          m_rem;

  always @(posedge Clock or posedge Reset) begin
    logic [15:0] r;
    logic c, o, cv, ov;
    if (Reset) begin
      m_flags <= '0; m_prod <= '0; m_pend <= '0; m_done <= 1'b0; m_wf <= 1'b0; m_rem <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_prod <= m_pend;
          m_done <= 1'b1;
          if (m_wf) m_flags <= {m_pend == 32'd0, m_pend[31:16] != 16'd0, m_pend[15], 1'b0};
        end
      end else begin
        if (FunSel == 4'hF && Start) begin
          m_rem  <= 16;
          m_pend <= 32'(A) * 32'(B);
          m_wf   <= WF;
        end
        if (WF && FunSel != 4'hF) begin
          ref_op(FunSel, A, B, m_flags[2], r, c, o, cv, ov);
          m_flags <= {r == 16'd0, cv ? c : m_flags[2], r[15], ov ? o : m_flags[0]};
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge Clock) begin
    logic [15:0] r, exp_alu;
    logic c, o, cv, ov;
    ref_op(FunSel, A, B, m_flags[2], r, c, o, cv, ov);
    exp_alu = (FunSel == 4'hF) ? m_prod[15:0] : r;
    chk("model_aluout", 32'(ALUOut), 32'(exp_alu));
    chk("model_mulhi", 32'(MulHi), 32'(m_prod[31:16]));
    chk("model_flags", 32'(FlagsOut), 32'(m_flags));
    chk("model_busy", 32'(Busy), 32'(m_rem > 0));
    chk("model_done", 32'(Done), 32'(m_done));
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  // Waits for Done with a cycle bound; returns number of Busy samples seen.
  task automatic wait_done(input string name, output int busy_cnt);
    bit seen;
    busy_cnt = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (Done) begin seen = 1; break; end
      if (Busy) busy_cnt++;
      step();
    end
    if (!seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s: Done never seen within 40 cycles", name);
    end
  endtask

  initial begin
    int bc, done_cnt;
    step(); step();
    chk("rst_flags", 32'(FlagsOut), 32'h0);
    chk("rst_busy", 32'(Busy), 32'h0);
    FunSel = 4'hF;
    #1 chk("rst_mul_aluout", 32'(ALUOut), 32'h0);
    Reset = 1'b0;
    step();

    // ADD overflow
    FunSel = 4'h4; A = 16'h7FFF; B = 16'h0001; WF = 1;
    #1 chk("add_aluout", 32'(ALUOut), 32'h8000);
    step(); WF = 0;
    chk("add_flags", 32'(FlagsOut), 32'b0011);

    // SUB equal, then WF=0 holds
    FunSel = 4'h6; A = 16'h0005; B = 16'h0005; WF = 1;
    #1 chk("sub_aluout", 32'(ALUOut), 32'h0);
    step(); WF = 0;
    chk("sub_flags", 32'(FlagsOut), 32'b1100);
    A = 16'h0001; B = 16'h0002;
    step();
    chk("sub_hold_flags", 32'(FlagsOut), 32'b1100);

    // LSL then CSL rotating C in
    FunSel = 4'hB; A = 16'h8001; WF = 1;
    #1 chk("lsl_aluout", 32'(ALUOut), 32'h0002);
    step();
    chk("lsl_flags", 32'(FlagsOut), 32'b0100);
    FunSel = 4'hE; A = 16'h0000;
    #1 chk("csl_aluout", 32'(ALUOut), 32'h0001);
    step(); WF = 0;
    chk("csl_flags", 32'(FlagsOut), 32'b0000);

    // MUL 0x1234 * 0x0100
    FunSel = 4'hF; A = 16'h1234; B = 16'h0100; WF = 1; Start = 1;
    step(); Start = 0; A = 16'hDEAD; B = 16'hBEEF;
    wait_done("mul1_done", bc);
    chk("mul1_busy_cycles", 32'(bc), 32'd16);
    chk("mul1_busy_in_done", 32'(Busy), 32'h0);
    chk("mul1_aluout", 32'(ALUOut), 32'h3400);
    chk("mul1_mulhi", 32'(MulHi), 32'h0012);
    chk("mul1_flags", 32'(FlagsOut), 32'b0100);
    step();
    chk("mul1_done_pulse", 32'(Done), 32'h0);

    // MUL 0xFFFF^2 with an ignored Start while busy, restart from Done
    A = 16'hFFFF; B = 16'hFFFF; Start = 1;
    step(); Start = 0;
    step(); step(); step();
    A = 16'h0002; B = 16'h0003; Start = 1;
    step(); Start = 0;
    wait_done("mul2_done", bc);
    chk("mul2_mulhi", 32'(MulHi), 32'hFFFE);
    chk("mul2_aluout", 32'(ALUOut), 32'h0001);
    chk("mul2_flags", 32'(FlagsOut), 32'b0100);
    A = 16'h0003; B = 16'h0005; Start = 1;
    step(); Start = 0;
    chk("mul3_restart_busy", 32'(Busy), 32'h1);
    for (int i = 0; i < 7; i++) step();

    // Abort at iteration 7
    Reset = 1;
    #1;
    chk("abort_busy", 32'(Busy), 32'h0);
    chk("abort_mulhi", 32'(MulHi), 32'h0);
    chk("abort_flags", 32'(FlagsOut), 32'h0);
    step(); Reset = 0;
    done_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (Done) done_cnt++;
    end
    chk("abort_no_done", 32'(done_cnt), 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      FunSel = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      A      = 16'($urandom);
      B      = 16'($urandom);
      WF     = 1'($urandom_range(0, 1));
      Start  = ($urandom_range(0, 2) == 0);
      Reset  = ($urandom_range(0, 299) == 0);
      step();
      Reset  = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
